glitch_sweep_ctrl: RTL and testbench

//  Sequences a fault-injection campaign on the glitchy-clock generator.

---
 rtl/glitch_sweep_ctrl.sv | 177 +++++++++++++++++
 tb/tb_glitch_sweep_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sweep_ctrl.sv
// Fault-injection campaign sequencer: sweeps phase (outer) and glitch position (inner),
// fires one glitched encryption per point and reports one result record per trial.
module glitch_sweep_ctrl #(
  parameter int PHASE_W    = 8,
  parameter int POS_W      = 16,
  parameter int SETTLE_CYC = 512,
  parameter int TMO_CYC    = 65535
) (
  input  logic               clk,
  input  logic               rstnin,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] phase_min,
  input  logic [PHASE_W-1:0] phase_max,
  input  logic [POS_W-1:0]   pos_min,
  input  logic [POS_W-1:0]   pos_max,
  input  logic [POS_W-1:0]   pos_step,
  input  logic               dll_locked,
  input  logic               enc_done,
  input  logic               fault_flag,
  output logic [PHASE_W-1:0] phase,
  output logic [POS_W-1:0]   glitch_pos,
  output logic               glitch_en,
  output logic               start_enc,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [PHASE_W-1:0] res_phase,
  output logic [POS_W-1:0]   res_pos,
  output logic               res_fault,
  output logic               res_tmo,
  output logic               busy,
  output logic               done
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TMO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_FIRE, S_WAIT_DONE, S_REPORT, S_NEXT, S_FINISH
  } state_t;

  state_t             state_r;
  logic [SET_W-1:0]   settle_cnt_r;
  logic [TMO_W-1:0]   tmo_cnt_r;
  logic [PHASE_W-1:0] phase_max_r;
  logic [POS_W-1:0]   pos_min_r;
  logic [POS_W-1:0]   pos_max_r;
  logic [POS_W-1:0]   pos_step_r;
  logic               lock_meta_r;
  logic               lock_sync_r;
  logic [POS_W:0]     pos_sum_s;

  // One extra bit so a carry out of the position add reads as "past pos_max".
  assign pos_sum_s = {1'b0, glitch_pos} + {1'b0, pos_step_r};

  // Two-flop synchroniser for the asynchronous DLL lock.
  always_ff @(posedge clk or negedge rstnin) begin
    if (!rstnin) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= dll_locked;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Sweep sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rstnin) begin
    if (!rstnin) begin
      state_r      <= S_IDLE;
      settle_cnt_r <= '0;
      tmo_cnt_r    <= '0;
      phase_max_r  <= '0;
      pos_min_r    <= '0;
      pos_max_r    <= '0;
      pos_step_r   <= '0;
      phase        <= '0;
      glitch_pos   <= '0;
      glitch_en    <= 1'b0;
      start_enc    <= 1'b0;
      res_valid    <= 1'b0;
      res_phase    <= '0;
      res_pos      <= '0;
      res_fault    <= 1'b0;
      res_tmo      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      start_enc <= 1'b0;
      done      <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            phase_max_r <= phase_max;
            pos_min_r   <= pos_min;
            pos_max_r   <= pos_max;
            pos_step_r  <= (pos_step == '0) ? POS_W'(1) : pos_step;
            if (abort || (phase_min > phase_max) || (pos_min > pos_max)) begin
              state_r <= S_FINISH;
            end else begin
              phase        <= phase_min;
              glitch_pos   <= pos_min;
              busy         <= 1'b1;
              settle_cnt_r <= '0;
              state_r      <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (abort) begin
            state_r <= S_FINISH;
          end else if (settle_cnt_r != SETTLE_LAST) begin
            settle_cnt_r <= settle_cnt_r + SET_W'(1);
          end else if (lock_sync_r) begin
            glitch_en <= 1'b1;
            start_enc <= 1'b1;
            state_r   <= S_FIRE;
          end
        end
        S_FIRE: begin
          tmo_cnt_r <= '0;
          state_r   <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (enc_done || (tmo_cnt_r == TMO_LAST)) begin
            res_fault <= enc_done & fault_flag;
            res_tmo   <= ~enc_done;
            res_phase <= phase;
            res_pos   <= glitch_pos;
            res_valid <= 1'b1;
            glitch_en <= 1'b0;
            state_r   <= S_REPORT;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_r   <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (abort) begin
            state_r <= S_FINISH;
          end else if (pos_sum_s <= {1'b0, pos_max_r}) begin
            glitch_pos <= pos_sum_s[POS_W-1:0];
            glitch_en  <= 1'b1;
            start_enc  <= 1'b1;
            state_r    <= S_FIRE;
          end else if (phase < phase_max_r) begin
            phase        <= phase + PHASE_W'(1);
            glitch_pos   <= pos_min_r;
            settle_cnt_r <= '0;
            state_r      <= S_SETTLE;
          end else begin
            state_r <= S_FINISH;
          end
        end
        S_FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          glitch_en <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Directed bench for glitch_sweep_ctrl with a modelled target that answers start_enc.
module tb_glitch_sweep_ctrl;
  localparam int PW  = 8;
  localparam int QW  = 16;
  localparam int SET = 20;
  localparam int TMO = 100;

  logic clk, rstnin, start, abort, dll_locked, enc_done, fault_flag, res_ready;
  logic [PW-1:0] phase_min, phase_max, phase, res_phase;
  logic [QW-1:0] pos_min, pos_max, pos_step, glitch_pos, res_pos;
  logic glitch_en, start_enc, res_valid, res_fault, res_tmo, busy, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic          resp_en = 1'b1;
  int            resp_delay = 5;
  int            resp_cnt = 0;
  int            resp_trial = 0;

  logic [PW-1:0] rec_phase[$];
  logic [QW-1:0] rec_pos[$];
  logic          rec_fault[$];
  logic          rec_tmo[$];
  int            rec_cyc[$];
  int            se_cyc[$];
  int            done_cyc[$];

  glitch_sweep_ctrl #(.PHASE_W(PW), .POS_W(QW), .SETTLE_CYC(SET), .TMO_CYC(TMO)) dut (
    .clk(clk), .rstnin(rstnin), .start(start), .abort(abort),
    .phase_min(phase_min), .phase_max(phase_max),
    .pos_min(pos_min), .pos_max(pos_max), .pos_step(pos_step),
    .dll_locked(dll_locked), .enc_done(enc_done), .fault_flag(fault_flag),
    .phase(phase), .glitch_pos(glitch_pos), .glitch_en(glitch_en), .start_enc(start_enc),
    .res_valid(res_valid), .res_ready(res_ready), .res_phase(res_phase), .res_pos(res_pos),
    .res_fault(res_fault), .res_tmo(res_tmo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log handshakes, start_enc pulses and done pulses with their cycle stamps.
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      rec_phase.push_back(res_phase);
      rec_pos.push_back(res_pos);
      rec_fault.push_back(res_fault);
      rec_tmo.push_back(res_tmo);
      rec_cyc.push_back(cyc);
    end
    if (start_enc) se_cyc.push_back(cyc);
    if (done) done_cyc.push_back(cyc);
  end

  // Target model: enc_done resp_delay cycles after start_enc; fault on odd trials.
  initial begin
    enc_done = 1'b0;
    fault_flag = 1'b1;
    forever begin
      @(posedge clk); #1;
      enc_done = 1'b0;
      fault_flag = 1'b1;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          enc_done = 1'b1;
          fault_flag = resp_trial[0];
        end
      end
      if (start_enc && resp_en) begin
        resp_trial++;
        resp_cnt = resp_delay;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    rec_phase.delete(); rec_pos.delete(); rec_fault.delete(); rec_tmo.delete();
    rec_cyc.delete(); se_cyc.delete(); done_cyc.delete();
    resp_trial = 0;
  endtask

  // Pulse start with a config, then scramble the config inputs to prove they were latched.
  task automatic run_sweep(input logic [PW-1:0] pmin, input logic [PW-1:0] pmax,
                           input logic [QW-1:0] qmin, input logic [QW-1:0] qmax,
                           input logic [QW-1:0] qstep);
    phase_min = pmin; phase_max = pmax; pos_min = qmin; pos_max = qmax; pos_step = qstep;
    start = 1'b1;
    tick();
    start = 1'b0;
    phase_min = 8'hA5; phase_max = 8'h00; pos_min = 16'h1234; pos_max = 16'h0001; pos_step = 16'h0003;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done_cyc.size() > 0) begin ok = 1'b1; break; end
    end
    tick(2);
  endtask

  task automatic test_reset();
    rstnin = 1'b0;
    tick(2);
    checks++;
    if ({phase, glitch_pos, glitch_en, start_enc, res_valid, res_phase, res_pos,
         res_fault, res_tmo, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got phase=%h pos=%h ge=%b se=%b rv=%b rp=%h rq=%h rf=%b rt=%b dn=%b, want all 0",
               phase, glitch_pos, glitch_en, start_enc, res_valid, res_phase, res_pos, res_fault, res_tmo, done);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    rstnin = 1'b1;
    tick(3);
  endtask

  task automatic test_basic_sweep();
    bit ok;
    clear_mon();
    run_sweep(8'd3, 8'd4, 16'd10, 16'd30, 16'd10);
    tick(3);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b want 1", busy); end
    tick(10);
    phase_min = 8'd0; phase_max = 8'd0; pos_min = 16'd0; pos_max = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(2000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_done: got no done pulse, want one"); end
    checks++;
    if (rec_pos.size() !== 6) begin failures++; $display("FAIL basic_count: got %0d records want 6", rec_pos.size()); end
    for (int i = 0; i < rec_pos.size() && i < 6; i++) begin
      checks++;
      if (rec_phase[i] !== PW'(3 + i / 3) || rec_pos[i] !== QW'(10 + 10 * (i % 3)) ||
          rec_fault[i] !== ((i % 2) == 0) || rec_tmo[i] !== 1'b0) begin
        failures++;
        $display("FAIL basic_rec%0d: got (%0d,%0d,f%b,t%b) want (%0d,%0d,f%b,t0)", i, rec_phase[i], rec_pos[i],
                 rec_fault[i], rec_tmo[i], 3 + i / 3, 10 + 10 * (i % 3), (i % 2) == 0);
      end
    end
    checks++;
    if (se_cyc.size() !== 6) begin
      failures++; $display("FAIL basic_start_enc: got %0d pulses want 6", se_cyc.size());
    end else begin
      checks++;
      if (se_cyc[1] - se_cyc[0] !== 8) begin
        failures++; $display("FAIL basic_gap_nosettle: got %0d want 8", se_cyc[1] - se_cyc[0]);
      end
      checks++;
      if (se_cyc[3] - se_cyc[2] !== 8 + SET) begin
        failures++; $display("FAIL basic_gap_settle: got %0d want %0d", se_cyc[3] - se_cyc[2], 8 + SET);
      end
    end
    checks++;
    if (done_cyc.size() !== 1 || busy !== 1'b0 || glitch_en !== 1'b0) begin
      failures++;
      $display("FAIL basic_end: got done=%0d busy=%b ge=%b want 1,0,0", done_cyc.size(), busy, glitch_en);
    end
  endtask

  task automatic test_pos_no_wrap();
    bit ok;
    clear_mon();
    run_sweep(8'd0, 8'd0, 16'hFFF0, 16'hFFFF, 16'h0010);
    wait_done(500, ok);
    checks++;
    if (!ok || rec_pos.size() !== 1) begin
      failures++; $display("FAIL nowrap_count: got done=%b records=%0d want 1,1", ok, rec_pos.size());
    end else begin
      checks++;
      if (rec_pos[0] !== 16'hFFF0 || rec_phase[0] !== 8'd0) begin
        failures++; $display("FAIL nowrap_rec: got (%h,%h) want (00,fff0)", rec_phase[0], rec_pos[0]);
      end
    end
  endtask

  task automatic test_step_zero();
    bit ok;
    clear_mon();
    run_sweep(8'd7, 8'd7, 16'd5, 16'd7, 16'd0);
    wait_done(500, ok);
    checks++;
    if (!ok || rec_pos.size() !== 3) begin
      failures++; $display("FAIL step0_count: got done=%b records=%0d want 1,3", ok, rec_pos.size());
    end else begin
      checks++;
      if (rec_pos[0] !== 16'd5 || rec_pos[1] !== 16'd6 || rec_pos[2] !== 16'd7) begin
        failures++; $display("FAIL step0_pos: got %0d,%0d,%0d want 5,6,7", rec_pos[0], rec_pos[1], rec_pos[2]);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_mon();
    resp_en = 1'b0;
    run_sweep(8'd1, 8'd1, 16'd7, 16'd7, 16'd1);
    wait_done(1000, ok);
    resp_en = 1'b1;
    checks++;
    if (!ok || rec_pos.size() !== 1 || se_cyc.size() !== 1) begin
      failures++; $display("FAIL tmo_count: got done=%b records=%0d want 1,1", ok, rec_pos.size());
    end else begin
      checks++;
      if (rec_tmo[0] !== 1'b1 || rec_fault[0] !== 1'b0) begin
        failures++; $display("FAIL tmo_flags: got tmo=%b fault=%b want 1,0", rec_tmo[0], rec_fault[0]);
      end
      checks++;
      if (rec_cyc[0] - se_cyc[0] !== TMO + 1) begin
        failures++; $display("FAIL tmo_latency: got %0d want %0d", rec_cyc[0] - se_cyc[0], TMO + 1);
      end
    end
  endtask

  task automatic test_tmo_race();
    bit ok;
    clear_mon();
    resp_delay = TMO;
    run_sweep(8'd2, 8'd2, 16'd9, 16'd9, 16'd1);
    wait_done(1000, ok);
    resp_delay = 5;
    checks++;
    if (!ok || rec_pos.size() !== 1 || se_cyc.size() !== 1) begin
      failures++; $display("FAIL race_count: got done=%b records=%0d want 1,1", ok, rec_pos.size());
    end else begin
      checks++;
      if (rec_tmo[0] !== 1'b0 || rec_fault[0] !== 1'b1 || rec_cyc[0] - se_cyc[0] !== TMO + 1) begin
        failures++;
        $display("FAIL race_done_wins: got tmo=%b fault=%b lat=%0d want 0,1,%0d",
                 rec_tmo[0], rec_fault[0], rec_cyc[0] - se_cyc[0], TMO + 1);
      end
    end
  endtask

  task automatic test_lock();
    bit ok;
    int lock_cyc;
    dll_locked = 1'b0;
    tick(3);
    clear_mon();
    run_sweep(8'd2, 8'd2, 16'd1, 16'd1, 16'd1);
    tick(2000);
    checks++;
    if (se_cyc.size() !== 0 || busy !== 1'b1) begin
      failures++; $display("FAIL lock_hold: got start_enc=%0d busy=%b want 0,1", se_cyc.size(), busy);
    end
    dll_locked = 1'b1;
    lock_cyc = cyc;
    wait_done(500, ok);
    checks++;
    if (!ok || se_cyc.size() !== 1) begin
      failures++; $display("FAIL lock_fire: got done=%b start_enc=%0d want 1,1", ok, se_cyc.size());
    end else begin
      checks++;
      if (se_cyc[0] - lock_cyc !== 3) begin
        failures++; $display("FAIL lock_sync_latency: got %0d want 3", se_cyc[0] - lock_cyc);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    int bad;
    logic [PW-1:0] sp;
    logic [QW-1:0] sq;
    logic sf, st;
    clear_mon();
    res_ready = 1'b0;
    run_sweep(8'd0, 8'd0, 16'd1, 16'd2, 16'd1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (res_valid === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL bp_valid: got no res_valid want 1"); end
    sp = res_phase; sq = res_pos; sf = res_fault; st = res_tmo;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_phase !== sp || res_pos !== sq || res_fault !== sf || res_tmo !== st)
        bad++;
    end
    checks++;
    if (bad !== 0 || sq !== 16'd1) begin
      failures++; $display("FAIL bp_stable: got %0d unstable cycles pos=%0d want 0,1", bad, sq);
    end
    checks++;
    if (se_cyc.size() !== 1) begin
      failures++; $display("FAIL bp_no_fire: got %0d start_enc want 1", se_cyc.size());
    end
    res_ready = 1'b1;
    wait_done(500, ok);
    checks++;
    if (!ok || rec_pos.size() !== 2) begin
      failures++; $display("FAIL bp_count: got done=%b records=%0d want 1,2", ok, rec_pos.size());
    end
  endtask

  task automatic test_abort();
    bit ok;
    clear_mon();
    run_sweep(8'd0, 8'd1, 16'd1, 16'd3, 16'd1);
    for (int i = 0; i < 500; i++) begin
      tick();
      if (se_cyc.size() == 2) break;
    end
    abort = 1'b1;
    wait_done(500, ok);
    abort = 1'b0;
    checks++;
    if (!ok || rec_pos.size() !== 2 || se_cyc.size() !== 2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_end: got done=%b records=%0d start_enc=%0d busy=%b want 1,2,2,0",
               ok, rec_pos.size(), se_cyc.size(), busy);
    end else begin
      checks++;
      if (rec_pos[1] !== 16'd2 || rec_phase[1] !== 8'd0) begin
        failures++; $display("FAIL abort_rec: got (%0d,%0d) want (0,2)", rec_phase[1], rec_pos[1]);
      end
    end
  endtask

  task automatic test_empty();
    bit ok;
    int s_cyc;
    clear_mon();
    s_cyc = cyc;
    run_sweep(8'd5, 8'd2, 16'd0, 16'd0, 16'd1);
    wait_done(50, ok);
    checks++;
    if (!ok || done_cyc.size() !== 1) begin
      failures++; $display("FAIL empty_done: got done=%b count=%0d want 1,1", ok, done_cyc.size());
    end else begin
      checks++;
      if (done_cyc[0] - s_cyc !== 2) begin
        failures++; $display("FAIL empty_latency: got %0d want 2", done_cyc[0] - s_cyc);
      end
    end
    checks++;
    if (rec_pos.size() !== 0 || se_cyc.size() !== 0) begin
      failures++; $display("FAIL empty_records: got %0d rec %0d start_enc want 0,0", rec_pos.size(), se_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    clear_mon();
    resp_en = 1'b0;
    run_sweep(8'd0, 8'd0, 16'd1, 16'd1, 16'd1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (glitch_en === 1'b1) begin seen = 1'b1; break; end
    end
    tick(2);
    rstnin = 1'b0;
    #1;
    checks++;
    if (!seen || glitch_en !== 1'b0 || start_enc !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got armed=%b ge=%b se=%b busy=%b want 1,0,0,0", seen, glitch_en, start_enc, busy);
    end
    tick();
    rstnin = 1'b1;
    resp_en = 1'b1;
    tick(3);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid_idle: got rv=%b busy=%b want 0,0", res_valid, busy);
    end
  endtask

  initial begin
    rstnin = 1'b0; start = 1'b0; abort = 1'b0; dll_locked = 1'b1; res_ready = 1'b1;
    phase_min = '0; phase_max = '0; pos_min = '0; pos_max = '0; pos_step = '0;
    test_reset();
    test_basic_sweep();
    test_pos_no_wrap();
    test_step_zero();
    test_timeout();
    test_tmo_race();
    test_lock();
    test_backpressure();
    test_abort();
    test_empty();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
